// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter with fractional baud correction
// and idle-line handoff to a secondary UART source.
module uart_tx #(
  parameter int CLK_RATE  = 100 * 10**6,
  parameter int BAUD_RATE = 115200
) (
  input  logic       CLK_I,
  input  logic       RST_NI,
  input  logic       TX_START_I,
  input  logic [7:0] DATA_I,
  output logic       TX_READY_O,
  output logic       TX_DONE_O,
  input  logic       CHANNEL_I,
  input  logic       TX1_I,
  output logic       TX0_O
);

  localparam int SAMPLE_INTERVAL =
    CLK_RATE / BAUD_RATE;
  localparam int REMAINDER_INTERVAL =
    ((CLK_RATE % BAUD_RATE) * 10) / BAUD_RATE;

  localparam int BAUD_W =
    $clog2(SAMPLE_INTERVAL + 1);
  localparam int REM_W =
    (REMAINDER_INTERVAL > 0) ?
    $clog2(REMAINDER_INTERVAL + 1) : 1;

  localparam logic [BAUD_W-1:0] LAST_SHORT =
    BAUD_W'(SAMPLE_INTERVAL - 1);
  localparam logic [BAUD_W-1:0] LAST_LONG =
    BAUD_W'(SAMPLE_INTERVAL);
  // The idle cycle carrying the done pulse is the
  // final cycle of the stop bit, so STOP is one short.
  localparam logic [BAUD_W-1:0] LAST_STOP =
    BAUD_W'(SAMPLE_INTERVAL - 2);
  localparam logic [REM_W-1:0] REM_LOAD =
    REM_W'(REMAINDER_INTERVAL);
  localparam logic [BAUD_W-1:0] BAUD_ONE =
    BAUD_W'(1);
  localparam logic [REM_W-1:0] REM_ONE =
    REM_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t            state_q, state_d;
  logic              line_q, line_d;
  logic              done_q, done_d;
  logic [7:0]        data_q, data_d;
  logic [2:0]        idx_q, idx_d;
  logic [2:0]        idx_next;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [BAUD_W-1:0] baud_last;
  logic              bit_long;
  logic              bit_end;
  logic              accept;

  assign accept   = TX_START_I && !CHANNEL_I;
  assign bit_long = (rem_q != '0);
  assign idx_next = idx_q + 3'd1;

  // Pick the terminal count of the current bit.
  always_comb begin
    baud_last = LAST_SHORT;
    unique case (1'b1)
      (state_q == STOP): baud_last = LAST_STOP;
      bit_long:          baud_last = LAST_LONG;
      default:           baud_last = LAST_SHORT;
    endcase
  end

  assign bit_end = (baud_q == baud_last);

  // Next-state, line level and counter updates.
  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    done_d  = 1'b0;
    data_d  = data_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    baud_d  = baud_q;

    if (state_q != IDLE) begin
      if (bit_end) begin
        baud_d = '0;
        if (bit_long)
          rem_d = rem_q - REM_ONE;
      end else begin
        baud_d = baud_q + BAUD_ONE;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = START;
          line_d  = 1'b0;
          data_d  = DATA_I;
          idx_d   = '0;
          rem_d   = REM_LOAD;
          baud_d  = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          line_d  = data_q[0];
          idx_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == 3'd7) begin
            state_d = STOP;
            line_d  = 1'b1;
          end else begin
            idx_d  = idx_next;
            line_d = data_q[idx_next];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          line_d  = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        line_d  = 1'b1;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      state_q <= IDLE;
      line_q  <= 1'b1;
      done_q  <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
      rem_q   <= '0;
      baud_q  <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      done_q  <= done_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      baud_q  <= baud_d;
    end
  end

  assign TX_READY_O = (state_q == IDLE);
  assign TX_DONE_O  = done_q;
  assign TX0_O =
    (state_q == IDLE && CHANNEL_I) ?
    TX1_I : line_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized frame checks of uart_tx against
// a bit-timing reference model, two baud configurations.
module tb_uart_tx;

  localparam int S  = 10;
  localparam int R0 = 0;
  localparam int R1 = 5;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b1;
  logic       start0 = 1'b0;
  logic       start1 = 1'b0;
  logic       chan   = 1'b0;
  logic       sec    = 1'b1;
  logic [7:0] data   = 8'h00;
  logic       ready0, done0, line0;
  logic       ready1, done1, line1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx #(
    .CLK_RATE(1000),
    .BAUD_RATE(100)
  ) dut (
    .CLK_I(clk),
    .RST_NI(rst_n),
    .TX_START_I(start0),
    .DATA_I(data),
    .TX_READY_O(ready0),
    .TX_DONE_O(done0),
    .CHANNEL_I(chan),
    .TX1_I(sec),
    .TX0_O(line0)
  );

  uart_tx #(
    .CLK_RATE(1050),
    .BAUD_RATE(100)
  ) dut_r (
    .CLK_I(clk),
    .RST_NI(rst_n),
    .TX_START_I(start1),
    .DATA_I(data),
    .TX_READY_O(ready1),
    .TX_DONE_O(done1),
    .CHANNEL_I(1'b0),
    .TX1_I(sec),
    .TX0_O(line1)
  );

  // Expected line level k cycles after the first
  // start-bit cycle: 10 bits, first r bits one longer.
  function automatic logic exp_level(
    input logic [7:0] d, input int s,
    input int r, input int k);
    logic [9:0] bits;
    int t;
    int len;
    bits = {1'b1, d, 1'b0};
    t = k;
    for (int b = 0; b < 10; b++) begin
      len = s + ((b < r) ? 1 : 0);
      if (t < len) return bits[b];
      t -= len;
    end
    return 1'b1;
  endfunction

  function automatic logic line_of(input bit sel);
    return sel ? line1 : line0;
  endfunction

  function automatic logic [1:0] flags_of(input bit sel);
    return sel ? {ready1, done1} : {ready0, done0};
  endfunction

  task automatic set_start(input bit sel, input logic v);
    if (sel) start1 = v;
    else start0 = v;
  endtask

  // Caller has just raised start at a negedge. Checks
  // every cycle of the frame; returns at the negedge of
  // its last cycle (the done cycle).
  // mode 1: keep start high and change data at k=0
  // mode 2: raise channel mid-frame
  // mode 3: one-cycle start pulse mid-frame
  task automatic check_frame(
    input bit sel, input logic [7:0] d,
    input int mode, input string name);
    int r;
    int len;
    logic [1:0] want_f;
    r   = sel ? R1 : R0;
    len = 10 * S + r;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      n_checks++;
      if (line_of(sel) !== exp_level(d, S, r, k)) begin
        n_fail++;
        $display("FAIL %s line k=%0d got %b want %b",
          name, k, line_of(sel), exp_level(d, S, r, k));
      end
      want_f = (k == len - 1) ? 2'b11 : 2'b00;
      n_checks++;
      if (flags_of(sel) !== want_f) begin
        n_fail++;
        $display("FAIL %s rdy/done k=%0d got %b want %b",
          name, k, flags_of(sel), want_f);
      end
      if (k == 0) begin
        if (mode == 1) begin
          data = 8'hC3;
        end else begin
          set_start(sel, 1'b0);
          data = 8'($urandom);
        end
      end
      if (mode == 2 && k == 30) begin
        chan = 1'b1;
        sec  = 1'b1;
      end
      if (mode == 3 && k == 40) set_start(sel, 1'b1);
      if (mode == 3 && k == 41) set_start(sel, 1'b0);
    end
  endtask

  task automatic check_idle(
    input int n, input string name);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      n_checks++;
      if ({line0, ready0, done0} !== 3'b110) begin
        n_fail++;
        $display("FAIL %s idle i=%0d got %b want 110",
          name, i, {line0, ready0, done0});
      end
    end
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({line0, ready0, done0, line1, ready1, done1}
        !== 6'b110110) begin
      n_fail++;
      $display("FAIL reset got %b want 110110",
        {line0, ready0, done0, line1, ready1, done1});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_idle(3, "post_reset");
  endtask

  task automatic test_basic;
    start0 = 1'b1;
    data   = 8'hA5;
    check_frame(1'b0, 8'hA5, 0, "a5");
    check_idle(3, "a5_after");
  endtask

  task automatic test_remainder;
    start1 = 1'b1;
    data   = 8'h00;
    check_frame(1'b1, 8'h00, 0, "rem00");
    @(negedge clk);
    n_checks++;
    if ({line1, ready1, done1} !== 3'b110) begin
      n_fail++;
      $display("FAIL rem_after got %b want 110",
        {line1, ready1, done1});
    end
  endtask

  task automatic test_back_to_back;
    start0 = 1'b1;
    data   = 8'h3C;
    check_frame(1'b0, 8'h3C, 1, "b2b_first");
    check_frame(1'b0, 8'hC3, 0, "b2b_second");
    check_idle(3, "b2b_after");
  endtask

  task automatic test_passthrough;
    logic v;
    @(negedge clk);
    chan   = 1'b1;
    start0 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      v   = 1'(i) ^ 1'($urandom);
      sec = v;
      #1;
      n_checks++;
      if ({line0, ready0, done0} !== {v, 2'b10}) begin
        n_fail++;
        $display("FAIL pass i=%0d got %b want %b",
          i, {line0, ready0, done0}, {v, 2'b10});
      end
    end
    @(negedge clk);
    start0 = 1'b0;
    chan   = 1'b0;
    sec    = 1'b1;
    check_idle(2, "pass_after");
  endtask

  task automatic test_channel_mid_frame;
    logic v;
    start0 = 1'b1;
    data   = 8'h81;
    check_frame(1'b0, 8'h81, 2, "chan_mid");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      v   = ~sec;
      sec = v;
      #1;
      n_checks++;
      if (line0 !== v) begin
        n_fail++;
        $display("FAIL chan_resume i=%0d got %b want %b",
          i, line0, v);
      end
    end
    @(negedge clk);
    chan = 1'b0;
    sec  = 1'b1;
    check_idle(2, "chan_after");
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] d;
    d = 8'($urandom) & 8'hEF;
    start0 = 1'b1;
    data   = d;
    for (int k = 0; k <= 54; k++) begin
      @(negedge clk);
      n_checks++;
      if (line0 !== exp_level(d, S, R0, k)) begin
        n_fail++;
        $display("FAIL rstmid line k=%0d got %b want %b",
          k, line0, exp_level(d, S, R0, k));
      end
      if (k == 0) start0 = 1'b0;
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({line0, ready0, done0} !== 3'b110) begin
      n_fail++;
      $display("FAIL rstmid async got %b want 110",
        {line0, ready0, done0});
    end
    check_idle(3, "rstmid_held");
    rst_n = 1'b1;
    check_idle(3, "rstmid_release");
    d = 8'($urandom);
    start0 = 1'b1;
    data   = d;
    check_frame(1'b0, d, 0, "rstmid_fresh");
    check_idle(2, "rstmid_after");
  endtask

  task automatic test_busy_pulse;
    logic [7:0] d;
    d = 8'($urandom);
    start0 = 1'b1;
    data   = d;
    check_frame(1'b0, d, 3, "busy");
    check_idle(20, "busy_after");
  endtask

  task automatic test_random;
    logic [7:0] d;
    bit sel;
    for (int i = 0; i < 6; i++) begin
      d   = 8'($urandom);
      sel = 1'($urandom);
      data = d;
      set_start(sel, 1'b1);
      check_frame(sel, d, 0, "rand");
      repeat (1 + $urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_remainder;
    test_back_to_back;
    test_passthrough;
    test_channel_mid_frame;
    test_reset_mid_frame;
    test_busy_pulse;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_checks, n_fail);
    $finish;
  end

endmodule
